// File: rtl/scr1_arch_types.sv
// scr1_arch_types: shared widths and the write-back load scoreboard entry type
package scr1_arch_types;
`ifdef SCR1_RVE_EXT
  localparam int SCR1_MPRF_ADDR_WIDTH = 4;
`else
  localparam int SCR1_MPRF_ADDR_WIDTH = 5;
`endif
  localparam int SCR1_XLEN = 32;
  typedef struct packed {
    logic                            vd;
    logic [SCR1_MPRF_ADDR_WIDTH-1:0] rd;
  } type_scr1_wb_sb_ent_s;
endpackage

// File: rtl/scr1_wb_sb_fifo.sv
// scr1_wb_sb_fifo: in-order scoreboard of outstanding load destinations with parallel hit lookup
module scr1_wb_sb_fifo
  import scr1_arch_types::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [SCR1_MPRF_ADDR_WIDTH-1:0] push_rd,
  input  logic                            pop,
  input  logic [SCR1_MPRF_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [SCR1_MPRF_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [SCR1_MPRF_ADDR_WIDTH-1:0] alu_rd,
  output logic                            full,
  output logic [SCR1_MPRF_ADDR_WIDTH-1:0] head_rd,
  output logic                            rs1_hit,
  output logic                            rs2_hit,
  output logic                            alu_hit
);
  localparam int PW = $clog2(LD_DEPTH);
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  type_scr1_wb_sb_ent_s ent [LD_DEPTH];
  // pointers carry an extra wrap bit so full and empty are distinguishable without a counter
  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
  assign head_rd = ent[rd_ptr[PW-1:0]].rd;
  // push fills the tail slot, pop retires the head slot; they never address the same slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < LD_DEPTH; i++) ent[i] <= '0;
    end else begin
      if (push) begin
        ent[wr_ptr[PW-1:0]] <= '{vd: 1'b1, rd: push_rd};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ent[rd_ptr[PW-1:0]].vd <= 1'b0;
        rd_ptr                 <= rd_ptr + 1'b1;
      end
    end
  end
  // compare every valid entry against the two read ports and the ALU destination
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    alu_hit = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      rs1_hit |= ent[i].vd & (ent[i].rd == rs1_addr);
      rs2_hit |= ent[i].vd & (ent[i].rd == rs2_addr);
      alu_hit |= ent[i].vd & (ent[i].rd == alu_rd);
    end
  end
`ifdef SCR1_SYN_OFF_EN
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && wr_ptr == rd_ptr));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
`endif
endmodule

// File: rtl/scr1_pipe_mprf_wb.sv
// scr1_pipe_mprf_wb: MPRF write-port arbiter, load scoreboard hazards and read bypass
module scr1_pipe_mprf_wb
  import scr1_arch_types::*;
#(
  parameter int LD_DEPTH = 2,
  parameter int ADDR_W   = SCR1_MPRF_ADDR_WIDTH,
  parameter int XLEN     = SCR1_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] exu_rs1_addr,
  input  logic [ADDR_W-1:0] exu_rs2_addr,
  input  logic [XLEN-1:0]   mprf_rs1_data,
  input  logic [XLEN-1:0]   mprf_rs2_data,
  output logic [XLEN-1:0]   wb_rs1_data,
  output logic [XLEN-1:0]   wb_rs2_data,
  output logic              wb_rs1_busy,
  output logic              wb_rs2_busy,
  input  logic              alu_wb_vd,
  input  logic [ADDR_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  output logic              alu_wb_rdy,
  input  logic              ld_issue_vd,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  output logic              ld_issue_rdy,
  input  logic              lsu_resp_vd,
  input  logic              lsu_resp_err,
  input  logic [XLEN-1:0]   lsu_resp_data,
  output logic              mprf_w_req,
  output logic [ADDR_W-1:0] mprf_rd_addr,
  output logic [XLEN-1:0]   mprf_rd_data
);
  logic              full;
  logic [ADDR_W-1:0] head_rd;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              alu_hit;
  logic              ld_wr;
  logic              alu_wr;
  scr1_wb_sb_fifo #(.LD_DEPTH(LD_DEPTH)) i_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ld_issue_vd & ld_issue_rdy),
    .push_rd  (ld_issue_rd),
    .pop      (lsu_resp_vd),
    .rs1_addr (exu_rs1_addr),
    .rs2_addr (exu_rs2_addr),
    .alu_rd   (alu_wb_rd),
    .full     (full),
    .head_rd  (head_rd),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .alu_hit  (alu_hit)
  );
  // load returns own the write port; the ALU also waits while a load to its rd is outstanding
  always_comb begin
    ld_issue_rdy = ~full;
    ld_wr        = lsu_resp_vd & ~lsu_resp_err & (head_rd != '0);
    alu_wb_rdy   = ~ld_wr & ~((alu_wb_rd != '0) & alu_hit);
    alu_wr       = alu_wb_vd & alu_wb_rdy & (alu_wb_rd != '0);
    mprf_w_req   = ld_wr | alu_wr;
    mprf_rd_addr = ld_wr ? head_rd : alu_wb_rd;
    mprf_rd_data = ld_wr ? lsu_resp_data : alu_wb_data;
    wb_rs1_busy  = (exu_rs1_addr != '0) & rs1_hit;
    wb_rs2_busy  = (exu_rs2_addr != '0) & rs2_hit;
  end
  // forward this cycle's write so EXU never sees stale MPRF contents; x0 always reads zero
  always_comb begin
    wb_rs1_data = (exu_rs1_addr == '0) ? '0
                : (mprf_w_req & (mprf_rd_addr == exu_rs1_addr)) ? mprf_rd_data : mprf_rs1_data;
    wb_rs2_data = (exu_rs2_addr == '0) ? '0
                : (mprf_w_req & (mprf_rd_addr == exu_rs2_addr)) ? mprf_rd_data : mprf_rs2_data;
  end
`ifdef SCR1_SYN_OFF_EN
  a_w_req_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(mprf_w_req));
`endif
endmodule
